plot_scheduler: RTL and testbench
=================================

PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter X_W, default 8, x-coordinate width (160-column display).
REQ-002 Parameter Y_W, default 7, y-coordinate width (120-row display).
REQ-003 Parameter COL_W, default 3, colour width.
REQ-004 Parameter TIMEOUT, default 64, maximum cycles one grant may be held.
REQ-005 clock  in  1  system clock (CLOCK_50 domain).
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse that starts a frame's plotting sequence.
REQ-008 req  in  2  per-requester "active this frame" flag; bit 0 = bird, bit 1 = hunter.
REQ-009 x0/y0/c0/plot0/done0  in  X_W/Y_W/COL_W/1/1  requester 0 pixel stream and completion pulse.
REQ-010 x1/y1/c1/plot1/done1  in  X_W/Y_W/COL_W/1/1  requester 1 pixel stream and completion pulse.
REQ-011 grant  out  2  one-hot (or zero) ownership of the plot port.
REQ-012 erase  out  1  high while the current grant is an erase pass.
REQ-013 vga_x/vga_y/vga_colour/vga_plot  out  X_W/Y_W/COL_W/1  single write port into the one vga_adapter.
REQ-014 busy  out  1  high from the cycle after an accepted frame_tick until return to IDLE.
REQ-015 overrun  out  1  sticky: frame_tick arrived while busy.
REQ-016 timeout_err  out  1  sticky: a grant was revoked by timeout.

Function
REQ-017 The FSM SHALL have states IDLE, ERASE, DRAW, GAP; all outputs are registered.
REQ-018 In IDLE, frame_tick SHALL latch req into req_mask, set busy, and enter ERASE at the next cycle with grant set to the first masked requester in round-robin order.
REQ-019 Round-robin order: pointer rr selects the first requester; rr toggles on every accepted frame_tick, including ticks with req_mask=0.
REQ-020 Sequence per frame: erase pass for each masked requester in order, then draw pass for each masked requester in the same order; erase=1 only during ERASE grants.
REQ-021 Changes to req after latching SHALL be ignored until the next accepted frame_tick.
REQ-022 done from the granted requester, sampled while its grant is high (including the first grant cycle), SHALL end the grant; grant drops next cycle (GAP, no grant), and the next grant asserts one cycle later.
REQ-023 done from a non-granted requester SHALL be ignored.
REQ-024 The port mux SHALL have a latency of one cycle: vga_* at cycle n+1 = granted requester's x/y/c/plot at cycle n; vga_plot=0 when no grant was held at cycle n.
REQ-025 During erase, vga_colour SHALL be forced to 0 (black) regardless of cN.
REQ-026 The pixel presented in the done cycle SHALL be forwarded (last pixel not lost).
REQ-027 After the last draw grant ends, the FSM SHALL return to IDLE and clear busy.
REQ-028 req_mask=0 at tick: the FSM SHALL return to IDLE after one cycle; busy pulses for one cycle and vga_plot stays 0.
REQ-029 frame_tick while busy SHALL be ignored (no restart, rr unchanged) and SHALL set overrun.
REQ-030 A frame_tick coinciding with the IDLE-return cycle SHALL count as busy.

Reset
REQ-031 resetn low SHALL asynchronously force IDLE, grant=0, erase=0, busy=0, vga_*=0, overrun=0, timeout_err=0, rr=0, req_mask=0, timeout counter=0.
REQ-032 Reset mid-grant SHALL abort the frame; after release, the block waits for a new frame_tick.

Configuration
REQ-033 Macro PLOT_TIMEOUT_EN defined: a counter SHALL clear at each grant start; if it reaches TIMEOUT-1 without done, the grant SHALL end as if done arrived, and timeout_err SHALL be set.
REQ-034 Macro PLOT_TIMEOUT_EN undefined: no counter SHALL be built, a grant is held until done, and timeout_err SHALL be tied to 0.

Verification
REQ-035 req=2'b11, rr=0, tick, each requester asserts done after 13 cycles -> grant sequence 01(erase),10(erase),01,10, one GAP cycle between each, 52 plot cycles, erase colours 000.
REQ-036 Second tick with req=2'b11 -> order starts with grant=10; third tick with req=2'b00 -> busy for 1 cycle, no plots, rr toggles.
REQ-037 req=2'b01, c0=3'b111, x0=5, y0=10, plot0=1 in grant cycle n -> vga_x=5, vga_y=10, vga_plot=1 at n+1; colour 000 in erase pass, 111 in draw pass.
REQ-038 tick mid-DRAW -> sequence unaffected, overrun=1 until resetn low; done1 pulsed while grant=01 -> ignored.
REQ-039 PLOT_TIMEOUT_EN, TIMEOUT=64, requester never asserts done -> grant drops after 64 cycles, timeout_err=1, frame completes; undefined -> grant held indefinitely.
REQ-040 resetn pulled low during the ERASE grant -> all outputs 0 immediately (asynchronously); no activity until the next tick.

Source files
------------

// File: rtl/plot_scheduler_if.sv
// Bundle between plot_scheduler and its two pixel requesters plus the shared vga_adapter write port.
// master = requester/display side, slave = the scheduler.
interface plot_scheduler_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
);
    logic             frame_tick;
    logic [1:0]       req;
    logic [X_W-1:0]   x0;
    logic [Y_W-1:0]   y0;
    logic [COL_W-1:0] c0;
    logic             plot0;
    logic             done0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y1;
    logic [COL_W-1:0] c1;
    logic             plot1;
    logic             done1;
    logic [1:0]       grant;
    logic             erase;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [COL_W-1:0] vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             overrun;
    logic             timeout_err;

    modport master (
        output frame_tick, req, x0, y0, c0, plot0, done0, x1, y1, c1, plot1, done1,
        input  grant, erase, vga_x, vga_y, vga_colour, vga_plot, busy, overrun, timeout_err
    );

    modport slave (
        input  frame_tick, req, x0, y0, c0, plot0, done0, x1, y1, c1, plot1, done1,
        output grant, erase, vga_x, vga_y, vga_colour, vga_plot, busy, overrun, timeout_err
    );
endinterface

// File: rtl/plot_scheduler.sv
// Per-frame arbiter giving two requesters (bird, hunter) an erase pass then a draw pass on one VGA write port.
// Optional grant watchdog: define PLOT_TIMEOUT_EN to revoke a grant held for TIMEOUT cycles.
module plot_scheduler #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    plot_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Steps 0/1 erase the first/second requester, steps 2/3 draw them; bit 0 picks the slot.
    function automatic logic [2:0] next_step(input logic [1:0] mask, input logic first,
                                             input logic [2:0] from);
        logic [2:0] res;
        logic [2:0] s3;
        res = 3'b000;
        for (int s = 3; s >= 0; s--) begin
            s3 = 3'(s);
            if ((s3 >= from) && mask[s3[0] ^ first]) begin
                res = {1'b1, s3[1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] step_grant(input logic [1:0] step, input logic first);
        return (step[0] ^ first) ? 2'b10 : 2'b01;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic             first_q, first_d;
    logic [1:0]       req_mask_q, req_mask_d;
    logic             rr_q, rr_d;
    logic [1:0]       grant_q, grant_d;
    logic             erase_q, erase_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic [COL_W-1:0] vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;
    logic [2:0]       ns_s;
    logic             done_s;
    logic             tmo_hit_s;
    logic             grant_start_s;

    assign done_s = |(grant_q & {bus.done1, bus.done0});

    // Frame sequencing: tick acceptance, pass selection, grant release and the GAP cycle.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        first_d       = first_q;
        req_mask_d    = req_mask_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        erase_d       = erase_q;
        busy_d        = busy_q;
        overrun_d     = overrun_q | (bus.frame_tick & busy_q);
        ns_s          = 3'b000;
        grant_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    req_mask_d = bus.req;
                    first_d    = rr_q;
                    rr_d       = ~rr_q;
                    busy_d     = 1'b1;
                    ns_s       = next_step(bus.req, rr_q, 3'd0);
                    if (ns_s[2]) begin
                        state_d       = ns_s[1] ? ST_DRAW : ST_ERASE;
                        step_d        = ns_s[1:0];
                        grant_d       = step_grant(ns_s[1:0], rr_q);
                        erase_d       = ~ns_s[1];
                        grant_start_s = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE, ST_DRAW: begin
                if (done_s || tmo_hit_s) begin
                    state_d = ST_GAP;
                    grant_d = 2'b00;
                    erase_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                ns_s = next_step(req_mask_q, first_q, {1'b0, step_q} + 3'd1);
                if (ns_s[2]) begin
                    state_d       = ns_s[1] ? ST_DRAW : ST_ERASE;
                    step_d        = ns_s[1:0];
                    grant_d       = step_grant(ns_s[1:0], first_q);
                    erase_d       = ~ns_s[1];
                    grant_start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                erase_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // One-cycle port mux; erase passes always write black.
    always_comb begin
        vga_x_d      = {X_W{1'b0}};
        vga_y_d      = {Y_W{1'b0}};
        vga_colour_d = {COL_W{1'b0}};
        vga_plot_d   = 1'b0;
        if (grant_q[0]) begin
            vga_x_d      = bus.x0;
            vga_y_d      = bus.y0;
            vga_colour_d = erase_q ? {COL_W{1'b0}} : bus.c0;
            vga_plot_d   = bus.plot0;
        end else if (grant_q[1]) begin
            vga_x_d      = bus.x1;
            vga_y_d      = bus.y1;
            vga_colour_d = erase_q ? {COL_W{1'b0}} : bus.c1;
            vga_plot_d   = bus.plot1;
        end else begin
            vga_plot_d   = 1'b0;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            step_q       <= 2'b00;
            first_q      <= 1'b0;
            req_mask_q   <= 2'b00;
            rr_q         <= 1'b0;
            grant_q      <= 2'b00;
            erase_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            vga_x_q      <= {X_W{1'b0}};
            vga_y_q      <= {Y_W{1'b0}};
            vga_colour_q <= {COL_W{1'b0}};
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            first_q      <= first_d;
            req_mask_q   <= req_mask_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            erase_q      <= erase_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

`ifdef PLOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign tmo_hit_s = (grant_q != 2'b00) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // Grant-hold counter restarts with every new grant; a hit without done is flagged.
    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        if (grant_start_s) begin
            tmo_cnt_d = {TMO_W{1'b0}};
        end else if ((grant_q != 2'b00) && !tmo_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
        if (tmo_hit_s && !done_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q     <= {TMO_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic tmo_unused_s;

    assign tmo_unused_s    = (TIMEOUT > 0) & grant_start_s;
    assign tmo_hit_s       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.erase      = erase_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: frame sequencing, round-robin, port mux latency, overrun and reset.
module tb_plot_scheduler;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    plot_scheduler_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus ();

    plot_scheduler #(.X_W(8), .Y_W(7), .COL_W(3), .TIMEOUT(64)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int len0 = 13;
    int len1 = 13;
    int cnt0 = 0;
    int cnt1 = 0;
    logic resp_done0 = 1'b0;
    logic resp_done1 = 1'b0;
    logic extra_done1 = 1'b0;
    logic [3:0]  trace[$];
    logic [18:0] vq[$];
    int plots, plots_black, plots_x5;

    assign bus.done0 = resp_done0;
    assign bus.done1 = resp_done1 | extra_done1;

    // Requesters: each raises done on the len-th cycle of its grant (len 0 = never).
    always @(negedge clock) begin
        if (bus.grant[0]) begin
            cnt0 <= cnt0 + 1;
            resp_done0 <= (len0 != 0) && (cnt0 + 1 == len0);
        end else begin
            cnt0 <= 0;
            resp_done0 <= 1'b0;
        end
        if (bus.grant[1]) begin
            cnt1 <= cnt1 + 1;
            resp_done1 <= (len1 != 0) && (cnt1 + 1 == len1);
        end else begin
            cnt1 <= 0;
            resp_done1 <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [1:0] r, input int ncyc, input int done1_at, input int tick_at);
        bus.req = r;
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        bus.req = ~r;
        trace.delete();
        vq.delete();
        plots = 0;
        plots_black = 0;
        plots_x5 = 0;
        for (int i = 0; i < ncyc; i++) begin
            trace.push_back({bus.busy, bus.erase, bus.grant});
            vq.push_back({bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y});
            if (bus.vga_plot) begin
                plots++;
                if (bus.vga_colour == 3'b000) plots_black++;
                if (bus.vga_x == 8'd5) plots_x5++;
            end
            extra_done1 = (i == done1_at);
            bus.frame_tick = (i == tick_at);
            @(negedge clock);
        end
        extra_done1 = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    // Full two-requester frame: four 13-cycle grants, one GAP after each, then IDLE.
    task automatic check_std(input string tag, input logic first1);
        logic [3:0] vals[$];
        int lens[$];
        logic [1:0] g1, g2;
        logic [3:0] ev[9];
        g1 = first1 ? 2'b10 : 2'b01;
        g2 = ~g1;
        ev = '{{2'b11, g1}, 4'b1000, {2'b11, g2}, 4'b1000,
               {2'b10, g1}, 4'b1000, {2'b10, g2}, 4'b1000, 4'b0000};
        foreach (trace[i]) begin
            if (vals.size() == 0 || trace[i] != vals[$]) begin
                vals.push_back(trace[i]);
                lens.push_back(1);
            end else begin
                lens[$] = lens[$] + 1;
            end
        end
        check({tag, "_nruns"}, vals.size(), 9);
        for (int k = 0; k < 9; k++) begin
            if (k < vals.size()) begin
                check($sformatf("%s_val%0d", tag, k), {28'd0, vals[k]}, {28'd0, ev[k]});
                if (k < 8) check($sformatf("%s_len%0d", tag, k), lens[k], (k % 2 == 0) ? 13 : 1);
            end
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.req = 2'b00;
        bus.x0 = 8'd5;   bus.y0 = 7'd10;  bus.c0 = 3'b111; bus.plot0 = 1'b1;
        bus.x1 = 8'd100; bus.y1 = 7'd100; bus.c1 = 3'b010; bus.plot1 = 1'b1;
        #2 resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_vga_plot", bus.vga_plot, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_timeout_err", bus.timeout_err, 1'b0);
        resetn = 1'b1;
        @(negedge clock);

        // Frame 1: both requesters, rr=0 -> bird first.
        do_frame(2'b11, 60, -1, -1);
        check_std("f1", 1'b0);
        check("f1_plots", plots, 52);
        check("f1_black", plots_black, 26);
        check("f1_bird_plots", plots_x5, 26);

        // Frame 2: rr=1 -> hunter first.
        do_frame(2'b11, 60, -1, -1);
        check_std("f2", 1'b1);

        // Frame 3: empty mask, one busy cycle and no plots.
        do_frame(2'b00, 4, -1, -1);
        check("f3_busy_pulse", trace[0], 4'b1000);
        check("f3_idle", trace[1], 4'b0000);
        check("f3_plots", plots, 0);
        check("f3_overrun", bus.overrun, 1'b0);

        // Frame 4: rr toggled by the empty tick; stray done1 during bird grant, tick during DRAW.
        do_frame(2'b11, 60, 19, 39);
        check_std("f4", 1'b1);
        check("f4_overrun", bus.overrun, 1'b1);

        // Frame 5: bird only; latency, black erase, coloured draw, last pixel kept.
        do_frame(2'b01, 32, -1, -1);
        check("f5_tr0", trace[0], 4'b1101);
        check("f5_tr12", trace[12], 4'b1101);
        check("f5_tr13", trace[13], 4'b1000);
        check("f5_tr14", trace[14], 4'b1001);
        check("f5_tr26", trace[26], 4'b1001);
        check("f5_tr27", trace[27], 4'b1000);
        check("f5_tr28", trace[28], 4'b0000);
        check("f5_vga0", vq[0], 19'd0);
        check("f5_vga1", vq[1], {1'b1, 3'b000, 8'd5, 7'd10});
        check("f5_vga13", vq[13], {1'b1, 3'b000, 8'd5, 7'd10});
        check("f5_vga14_plot", vq[14][18], 1'b0);
        check("f5_vga16", vq[16], {1'b1, 3'b111, 8'd5, 7'd10});
        check("f5_vga27", vq[27], {1'b1, 3'b111, 8'd5, 7'd10});
        check("f5_vga28_plot", vq[28][18], 1'b0);
        check("f5_plots", plots, 26);
        check("f5_black", plots_black, 13);
        check("f5_overrun_sticky", bus.overrun, 1'b1);

        // Frame 6: overrun tick must not have moved rr -> hunter first.
        do_frame(2'b11, 60, -1, -1);
        check_std("f6", 1'b1);

        // Frame 7: bird never signals done.
        len0 = 0;
        do_frame(2'b01, 70, -1, -1);
        check("f7_tr63", trace[63], 4'b1101);
`ifdef PLOT_TIMEOUT_EN
        check("f7_tr64", trace[64], 4'b1000);
        check("f7_tr69", trace[69], 4'b1001);
        check("f7_timeout_err", bus.timeout_err, 1'b1);
`else
        check("f7_tr64", trace[64], 4'b1101);
        check("f7_tr69", trace[69], 4'b1101);
        check("f7_timeout_err", bus.timeout_err, 1'b0);
`endif
        check("f7_vga_x_pre", bus.vga_x, 8'd5);

        // Asynchronous reset mid-grant, checked before any clock edge.
        #2 resetn = 1'b0;
        #1;
        check("arst_grant", bus.grant, 2'b00);
        check("arst_erase", bus.erase, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_vga_plot", bus.vga_plot, 1'b0);
        check("arst_vga_x", bus.vga_x, 8'd0);
        check("arst_overrun", bus.overrun, 1'b0);
        check("arst_timeout_err", bus.timeout_err, 1'b0);
        len0 = 13;
        @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        check("post_rst_idle", {bus.busy, bus.grant}, 3'b000);

        // Frame 8: rr back to 0 after reset -> bird first.
        do_frame(2'b11, 60, -1, -1);
        check_std("f8", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
